rob_retire_unit: RTL and testbench
==================================

ROB_RETIRE_UNIT -- requirements
Module: rob_retire_unit

Interface
- REQ-001 SHALL have parameter ROB_ENTRIES, default 16: ROB depth; PTR_WIDTH = $clog2(ROB_ENTRIES).
- REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100: exception redirect PC.
- REQ-003 SHALL use one clock; reset is synchronous and active-low.
- REQ-004 SHALL have port clk, input, 1: clock.
- REQ-005 SHALL have port rst_aL, input, 1: synchronous active-low reset.
- REQ-006 SHALL have port rob_deq_valid, input, 1: ROB head valid.
- REQ-007 SHALL have port rob_deq_data, input, rob_entry_t: ROB head entry.
- REQ-008 SHALL have port rob_deq_addr, input, PTR_WIDTH: ROB head ID.
- REQ-009 SHALL have port rob_deq_ready, output, 1: head retired this cycle.
- REQ-010 SHALL have port st_commit_valid, output, 1: store commit request.
- REQ-011 SHALL have port st_commit_ready, input, 1: store buffer accepts the commit.
- REQ-012 SHALL have port st_commit_rob_id, output, PTR_WIDTH: ROB ID of the committing store.
- REQ-013 SHALL have port arf_wr_en, output, 1: architectural register write enable.
- REQ-014 SHALL have port arf_wr_addr, output, 5: architectural register index.
- REQ-015 SHALL have port arf_wr_data, output, 32: write data.
- REQ-016 SHALL have port flush, output, 1: pipeline flush pulse.
- REQ-017 SHALL have port redirect_pc, output, 32: fetch redirect target, valid while flush=1.
- REQ-018 SHALL have port retired_count, output, 32: retired instruction counter.

Function
- REQ-019 SHALL retire at most one entry per cycle, in ROB order; retirement occurs iff rob_deq_valid && rob_deq_ready.
- REQ-020 SHALL assert rob_deq_ready combinationally only when: state==RUN, rob_deq_valid=1, done=1, and (is_store=0 or excp=1 or st_commit_ready=1).
- REQ-021 SHALL drive st_commit_valid = (state==RUN && rob_deq_valid && done && is_store && !excp); st_commit_rob_id = rob_deq_addr.
- REQ-022 SHALL register the ARF write: arf_wr_en=1 in the cycle after retiring an entry with reg_wr=1, excp=0, dst_arf!=0, carrying dst_arf/result; arf_wr_en=0 otherwise.
- REQ-023 SHALL implement states RUN and FLUSH; RUN->FLUSH on retiring an entry with excp=1 or mispred=1; FLUSH->RUN unconditionally after one cycle.
- REQ-024 SHALL, while in FLUSH, assert flush=1 for exactly one cycle with redirect_pc=TRAP_VEC if the entry had excp=1, else its target field; rob_deq_ready=0 and st_commit_valid=0 in FLUSH.
- REQ-025 SHALL give excp priority over mispred when both are set; an excepting entry performs no ARF write and no store commit.
- REQ-026 SHALL still write the ARF for a mispredicting entry without excp (e.g. JAL/JALR link register).
- REQ-027 SHALL increment retired_count by 1 per retirement, including excepting entries, wrapping modulo 2^32.
- REQ-028 SHALL hold the head (no retirement) while done=0, rob_deq_valid=0, or a store's st_commit_ready=0.
- REQ-029 SHALL leave rob_deq_data contents unobserved when rob_deq_valid=0.

Reset
- REQ-030 SHALL, on a clk edge with rst_aL=0: state=RUN, arf_wr_en=0, arf_wr_addr=0, arf_wr_data=0, flush=0, redirect_pc=0, retired_count=0.
- REQ-031 SHALL abandon a FLUSH in progress when reset hits mid-flush: no flush pulse in the cycle after reset.

Structure
- REQ-032 SHALL define rob_entry_t in the shared core package: done, excp, mispred, is_store, reg_wr (1 b each), dst_arf (5), result (32), target (32).
- REQ-033 SHALL define the FSM state enum (RUN, FLUSH) in the same package.
- REQ-034 SHALL be a single module with no sub-modules.

Verification
- REQ-035 SHALL check: head {done=1, reg_wr=1, dst_arf=5, result=32'hDEAD_BEEF} -> rob_deq_ready=1 the same cycle; next cycle arf_wr_en=1, addr=5, data=32'hDEAD_BEEF; retired_count=1.
- REQ-036 SHALL check: head done=0 for 3 cycles, then done=1 -> rob_deq_ready=0 for 3 cycles, then 1.
- REQ-037 SHALL check: store head, st_commit_ready=0 for 2 cycles -> st_commit_valid=1 with rob_deq_ready=0 for those cycles; retirement when ready=1.
- REQ-038 SHALL check: mispred=1, target=32'h0000_2000, reg_wr=1 -> next cycle flush=1, redirect_pc=32'h2000, arf_wr_en=1; a valid head is not retired during FLUSH.
- REQ-039 SHALL check: excp=1 and mispred=1 on a store -> no st_commit_valid, no ARF write, flush with redirect_pc=32'h100.
- REQ-040 SHALL check: retired_count preloaded near 32'hFFFF_FFFF by 10 retirements -> wraps to 0; rst_aL=0 in the FLUSH cycle -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rob_retire_unit_pkg.sv
// Shared core types for the in-order retirement stage: the ROB entry layout and
// the retire FSM states.
package rob_retire_unit_pkg;

  typedef struct packed {
    logic        done;
    logic        excp;
    logic        mispred;
    logic        is_store;
    logic        reg_wr;
    logic [4:0]  dst_arf;
    logic [31:0] result;
    logic [31:0] target;
  } rob_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } retire_state_e;

  // x0 is hardwired to zero, and an excepting entry never updates architectural state
  function automatic logic writes_arf(input rob_entry_t e);
    return e.reg_wr && !e.excp && (e.dst_arf != 5'd0);
  endfunction

endpackage

// File: rtl/rob_retire_unit.sv
// Retires the ROB head in order: commits stores, writes the ARF and raises a
// one-cycle flush with a redirect target on exceptions and mispredictions.
module rob_retire_unit
  import rob_retire_unit_pkg::*;
#(
  parameter int          ROB_ENTRIES = 16,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  localparam int         PTR_WIDTH   = $clog2(ROB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 rob_deq_valid,
  input  rob_entry_t           rob_deq_data,
  input  logic [PTR_WIDTH-1:0] rob_deq_addr,
  output logic                 rob_deq_ready,
  output logic                 st_commit_valid,
  input  logic                 st_commit_ready,
  output logic [PTR_WIDTH-1:0] st_commit_rob_id,
  output logic                 arf_wr_en,
  output logic [4:0]           arf_wr_addr,
  output logic [31:0]          arf_wr_data,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          retired_count
);

  retire_state_e state_r;
  retire_state_e state_nxt_s;
  logic          head_ready_s;
  logic          st_valid_s;
  logic          retire_s;
  logic          redirect_s;
  logic          arf_wr_en_r;
  logic [4:0]    arf_wr_addr_r;
  logic [31:0]   arf_wr_data_r;
  logic          flush_r;
  logic [31:0]   redirect_pc_r;
  logic [31:0]   retired_count_r;

  // Head handshake; a store that is not excepting must wait for the store buffer
  always_comb begin
    head_ready_s = 1'b0;
    st_valid_s   = 1'b0;
    if ((state_r == RUN) && rob_deq_valid && rob_deq_data.done) begin
      head_ready_s = !rob_deq_data.is_store || rob_deq_data.excp || st_commit_ready;
      st_valid_s   = rob_deq_data.is_store && !rob_deq_data.excp;
    end else begin
      head_ready_s = 1'b0;
      st_valid_s   = 1'b0;
    end
  end

  assign retire_s   = rob_deq_valid && head_ready_s;
  assign redirect_s = retire_s && (rob_deq_data.excp || rob_deq_data.mispred);

  // Next-state logic: FLUSH lasts exactly one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH:   state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered retirement side effects: ARF write, flush pulse, counter
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      arf_wr_en_r     <= 1'b0;
      arf_wr_addr_r   <= 5'd0;
      arf_wr_data_r   <= 32'd0;
      flush_r         <= 1'b0;
      redirect_pc_r   <= 32'd0;
      retired_count_r <= 32'd0;
    end else begin
      arf_wr_en_r <= retire_s && writes_arf(rob_deq_data);
      if (retire_s && writes_arf(rob_deq_data)) begin
        arf_wr_addr_r <= rob_deq_data.dst_arf;
        arf_wr_data_r <= rob_deq_data.result;
      end
      flush_r <= redirect_s;
      if (redirect_s) begin
        // Exception wins over misprediction when both are flagged
        redirect_pc_r <= rob_deq_data.excp ? TRAP_VEC : rob_deq_data.target;
      end
      if (retire_s) begin
        retired_count_r <= retired_count_r + 32'd1;
      end
    end
  end

  assign rob_deq_ready    = head_ready_s;
  assign st_commit_valid  = st_valid_s;
  assign st_commit_rob_id = rob_deq_addr;
  assign arf_wr_en        = arf_wr_en_r;
  assign arf_wr_addr      = arf_wr_addr_r;
  assign arf_wr_data      = arf_wr_data_r;
  assign flush            = flush_r;
  assign redirect_pc      = redirect_pc_r;
  assign retired_count    = retired_count_r;

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed and randomized checks of rob_retire_unit against a cycle-level
// behavioural model of the retirement rules.
module tb_rob_retire_unit;
  import rob_retire_unit_pkg::*;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        rob_deq_valid;
  rob_entry_t  rob_deq_data;
  logic [3:0]  rob_deq_addr;
  logic        rob_deq_ready;
  logic        st_commit_valid;
  logic        st_commit_ready;
  logic [3:0]  st_commit_rob_id;
  logic        arf_wr_en;
  logic [4:0]  arf_wr_addr;
  logic [31:0] arf_wr_data;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] retired_count;

  rob_retire_unit #(.ROB_ENTRIES(16), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .rob_deq_valid(rob_deq_valid), .rob_deq_data(rob_deq_data),
    .rob_deq_addr(rob_deq_addr), .rob_deq_ready(rob_deq_ready),
    .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
    .st_commit_rob_id(st_commit_rob_id),
    .arf_wr_en(arf_wr_en), .arf_wr_addr(arf_wr_addr), .arf_wr_data(arf_wr_data),
    .flush(flush), .redirect_pc(redirect_pc), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: what the registered outputs must show in the coming cycle
  logic        m_fl, m_wen;
  logic [31:0] m_pc, m_data, m_cnt;
  logic [4:0]  m_addr;
  logic [3:0]  rid;
  logic        retired_last;
  logic        obs_rdy, obs_stv, obs_fl, obs_wen;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rob_entry_t mk(input logic d, input logic x, input logic mp,
                                    input logic st, input logic rw, input logic [4:0] dst,
                                    input logic [31:0] res, input logic [31:0] tgt);
    rob_entry_t e;
    e.done = d; e.excp = x; e.mispred = mp; e.is_store = st; e.reg_wr = rw;
    e.dst_arf = dst; e.result = res; e.target = tgt;
    return e;
  endfunction

  function automatic rob_entry_t rand_entry();
    return mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
  endfunction

  task automatic reset_model();
    m_fl = 1'b0; m_wen = 1'b0; m_pc = 32'd0; m_data = 32'd0; m_cnt = 32'd0; m_addr = 5'd0;
  endtask

  // One clock cycle: drive after negedge, compare, then advance the model at posedge
  task automatic cyc(input logic v, input rob_entry_t e, input logic sr);
    logic exp_rdy, exp_stv;
    @(negedge clk);
    rob_deq_valid = v; rob_deq_data = e; rob_deq_addr = rid; st_commit_ready = sr;
    #1;
    exp_rdy = !m_fl && v && e.done && (!e.is_store || e.excp || sr);
    exp_stv = !m_fl && v && e.done && e.is_store && !e.excp;
    chk("deq_ready", rob_deq_ready, exp_rdy);
    chk("st_commit_valid", st_commit_valid, exp_stv);
    if (exp_stv) chk("st_commit_rob_id", st_commit_rob_id, rid);
    chk("flush", flush, m_fl);
    if (m_fl) chk("redirect_pc", redirect_pc, m_pc);
    chk("arf_wr_en", arf_wr_en, m_wen);
    if (m_wen) begin
      chk("arf_wr_addr", arf_wr_addr, m_addr);
      chk("arf_wr_data", arf_wr_data, m_data);
    end
    chk("retired_count", retired_count, m_cnt);
    obs_rdy = rob_deq_ready; obs_stv = st_commit_valid; obs_fl = flush;
    obs_wen = arf_wr_en; obs_pc = redirect_pc;
    @(posedge clk);
    retired_last = exp_rdy;
    if (exp_rdy) begin
      m_cnt = m_cnt + 32'd1;
      m_wen = e.reg_wr && !e.excp && (e.dst_arf != 5'd0);
      if (m_wen) begin
        m_addr = e.dst_arf;
        m_data = e.result;
      end
      m_fl = e.excp || e.mispred;
      m_pc = e.excp ? TRAP : e.target;
      rid  = rid + 4'd1;
    end else begin
      m_wen = 1'b0;
      m_fl  = 1'b0;
    end
  endtask

  rob_entry_t idle;
  rob_entry_t head;

  initial begin
    idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rst_aL = 1'b0; rob_deq_valid = 1'b0; rob_deq_data = idle;
    rob_deq_addr = 4'd0; st_commit_ready = 1'b0; rid = 4'd0; retired_last = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_flush", flush, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_arf_wr_en", arf_wr_en, 1'b0);
    chk("rst_arf_wr_addr", arf_wr_addr, 5'd0);
    chk("rst_arf_wr_data", arf_wr_data, 32'd0);
    chk("rst_retired_count", retired_count, 32'd0);
    chk("rst_deq_ready", rob_deq_ready, 1'b0);
    rst_aL = 1'b1;

    // Simple ALU retirement
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0), 1'b0);
    chk("alu_ready", obs_rdy, 1'b1);
    #1;
    chk("alu_wen", arf_wr_en, 1'b1);
    chk("alu_addr", arf_wr_addr, 5'd5);
    chk("alu_data", arf_wr_data, 32'hDEAD_BEEF);
    chk("alu_count", retired_count, 32'd1);

    // Head not done for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 32'd0), 1'b1);
      chk("notdone_ready", obs_rdy, 1'b0);
    end
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 32'd0), 1'b1);
    chk("done_ready", obs_rdy, 1'b1);

    // Store back-pressured for two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0), 1'b0);
      chk("st_wait_valid", obs_stv, 1'b1);
      chk("st_wait_ready", obs_rdy, 1'b0);
    end
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0), 1'b1);
    chk("st_go_ready", obs_rdy, 1'b1);

    // Mispredicted jump with link write; valid head held during FLUSH
    cyc(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_1234, 32'h0000_2000), 1'b0);
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h55, 32'd0), 1'b0);
    chk("mp_flush", obs_fl, 1'b1);
    chk("mp_pc", obs_pc, 32'h0000_2000);
    chk("mp_wen", obs_wen, 1'b1);
    chk("mp_hold", obs_rdy, 1'b0);
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h55, 32'd0), 1'b0);
    chk("mp_after_ready", obs_rdy, 1'b1);

    // Excepting, mispredicting store
    cyc(1'b1, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h99, 32'h0000_4000), 1'b1);
    chk("ex_stv", obs_stv, 1'b0);
    chk("ex_ready", obs_rdy, 1'b1);
    cyc(1'b0, idle, 1'b0);
    chk("ex_flush", obs_fl, 1'b1);
    chk("ex_pc", obs_pc, 32'h0000_0100);
    chk("ex_wen", obs_wen, 1'b0);

    // Counter wrap from a preloaded value
    @(negedge clk);
    force dut.retired_count_r = 32'hFFFF_FFF6;
    #1;
    release dut.retired_count_r;
    m_cnt = 32'hFFFF_FFF6;
    for (int i = 0; i < 10; i++)
      cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0), 1'b0);
    #1;
    chk("wrap_count", retired_count, 32'd0);

    // Reset landing in the FLUSH cycle
    cyc(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'hABCD, 32'h0000_3000), 1'b0);
    @(negedge clk);
    rst_aL = 1'b0; rob_deq_valid = 1'b0;
    #1;
    chk("rf_pre_flush", flush, 1'b1);
    @(posedge clk);
    #1;
    chk("rf_flush", flush, 1'b0);
    chk("rf_pc", redirect_pc, 32'd0);
    chk("rf_wen", arf_wr_en, 1'b0);
    chk("rf_addr", arf_wr_addr, 5'd0);
    chk("rf_data", arf_wr_data, 32'd0);
    chk("rf_count", retired_count, 32'd0);
    reset_model();
    @(negedge clk);
    rst_aL = 1'b1;
    cyc(1'b0, idle, 1'b0);

    // Randomized traffic; the head only changes once it retires
    head = rand_entry();
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom_range(0, 9) < 8), head, 1'($urandom_range(0, 1)));
      if (retired_last) head = rand_entry();
      else if (!head.done && ($urandom_range(0, 2) == 0)) head.done = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
